// File: rtl/cnt_stream_reader.sv
// rtl/cnt_stream_reader.sv - photon-count stream FIFO with Avalon-MM register port and level irq
// Optional sequence-gap checker: define CNT_STREAM_SEQ_CHECK_EN.
module cnt_stream_reader #(
    parameter int ADDR_W     = 4,
    parameter int IRQ_THRESH = 8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    input  logic [2:0]  avs_address,
    input  logic        avs_read,
    output logic [31:0] avs_readdata,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    output logic        irq
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] THRESH = (ADDR_W+1)'(IRQ_THRESH);
    localparam logic [ADDR_W:0] ONE    = {{ADDR_W{1'b0}}, 1'b1};

    logic [31:0]     mem [DEPTH];
    logic [ADDR_W:0] wptr, rptr, wptr_nxt, rptr_nxt, level, level_nxt;
    logic            empty, full, ctrl_wr, flush, clr, rd_data, pop, sample, push, drop;
    logic            overflow;
    logic [31:0]     drop_cnt, gaps_value, status, rd_mux;
    logic            unused_wdata;

    assign unused_wdata = ^avs_writedata[31:2];

    assign level   = wptr - rptr;
    assign empty   = (wptr == rptr);
    assign full    = (wptr[ADDR_W] != rptr[ADDR_W]) &&
                     (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]);
    assign ctrl_wr = avs_write && (avs_address == 3'd2);
    assign flush   = ctrl_wr && avs_writedata[0];
    assign clr     = ctrl_wr && avs_writedata[1];
    assign rd_data = avs_read && (avs_address == 3'd0);
    assign pop     = rd_data && !empty;
    // A sample arriving alongside a flush is discarded outright, never a drop.
    assign sample  = in_valid && !flush;
    assign push    = sample && (!full || pop);
    assign drop    = sample && full && !pop;

    always_comb begin
        wptr_nxt = wptr;
        rptr_nxt = rptr;
        if (flush) begin
            wptr_nxt = '0;
            rptr_nxt = '0;
        end else begin
            if (push) wptr_nxt = wptr + ONE;
            if (pop)  rptr_nxt = rptr + ONE;
        end
        level_nxt = wptr_nxt - rptr_nxt;
    end

    always_comb begin
        status             = '0;
        status[ADDR_W:0]   = level;
        status[16]         = empty;
        status[17]         = full;
        status[18]         = overflow;
    end

    always_comb begin
        rd_mux = '0;
        case (avs_address)
            3'd0:    rd_mux = empty ? '0 : mem[rptr[ADDR_W-1:0]];
            3'd1:    rd_mux = status;
            3'd3:    rd_mux = drop_cnt;
            3'd4:    rd_mux = gaps_value;
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (push) mem[wptr[ADDR_W-1:0]] <= in_data;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wptr         <= '0;
            rptr         <= '0;
            overflow     <= 1'b0;
            drop_cnt     <= '0;
            avs_readdata <= '0;
            irq          <= 1'b0;
        end else begin
            wptr         <= wptr_nxt;
            rptr         <= rptr_nxt;
            avs_readdata <= avs_read ? rd_mux : '0;
            irq          <= (level_nxt >= THRESH);
            if (clr) begin
                overflow <= 1'b0;
                drop_cnt <= '0;
            end else if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != 32'hFFFF_FFFF) drop_cnt <= drop_cnt + 32'd1;
            end
        end
    end

`ifdef CNT_STREAM_SEQ_CHECK_EN
    logic        armed;
    logic [31:0] expected, gap_cnt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            armed    <= 1'b0;
            expected <= '0;
            gap_cnt  <= '0;
        end else begin
            if (flush) begin
                armed <= 1'b0;
            end else if (sample) begin
                armed    <= 1'b1;
                expected <= in_data + 32'd1;
            end
            if (clr)
                gap_cnt <= '0;
            else if (sample && armed && (in_data != expected) && (gap_cnt != 32'hFFFF_FFFF))
                gap_cnt <= gap_cnt + 32'd1;
        end
    end

    assign gaps_value = gap_cnt;
`else
    assign gaps_value = '0;
`endif

endmodule
